// File: rtl/tia_pkg.sv
// Shared phase definitions for the TIA biphase delay logic.
// The phase-counter next-state function is reused by every block that must stay phase-aligned.
package tia_pkg;

    localparam int PH_W = 2;

    localparam logic [PH_W-1:0] PH_S1 = 2'd0;
    localparam logic [PH_W-1:0] PH_S2 = 2'd2;

    // Reset and resync both return the counter to the phase-1 strobe phase.
    function automatic logic [PH_W-1:0] phase_next(
        input logic [PH_W-1:0] ph,
        input logic            rst,
        input logic            sync
    );
        if (rst || sync) begin
            return '0;
        end
        return ph + PH_W'(1);
    endfunction

endpackage

// File: rtl/tia_d1r_stage.sv
// One WIDTH-bit master/slave delay stage.
// The master loads on cap_en and the slave copies the master on xfer_en.
module tia_d1r_stage #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             r,
    input  logic             cap_en,
    input  logic             xfer_en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] m;

    always_ff @(posedge clk) begin
        if (r) begin
            m <= '0;
            q <= '0;
        end else begin
            if (cap_en) begin
                m <= d;
            end
            if (xfer_en) begin
                q <= m;
            end
        end
    end

endmodule

// File: rtl/tia_d1r_chain.sv
// DEPTH-stage biphase delay chain with its own phase generator.
// Exports the phase strobes and the current phase so neighbours and checkers stay aligned.
module tia_d1r_chain
    import tia_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   r,
    input  logic                   rsyn,
    input  logic                   hold,
    input  logic [WIDTH-1:0]       in,
    output logic [WIDTH-1:0]       out,
    output logic [WIDTH*DEPTH-1:0] taps,
    output logic                   s1,
    output logic                   s2,
    output logic [PH_W-1:0]        phase_dbg
);

    logic [PH_W-1:0] phase;
    logic [PH_W-1:0] phase_d;
    logic            cap_en;
    logic            xfer_en;

    always_ff @(posedge clk) begin
        if (r) begin
            phase <= '0;
        end else begin
            phase <= phase_d;
        end
    end

    // Capture/transfer use the phase present before the edge, so rsyn never cancels them.
    always_comb begin
        phase_d = phase_next(phase, r, rsyn);
        s1      = (phase == PH_S1);
        s2      = (phase == PH_S2);
        cap_en  = (phase == PH_S1) && !hold;
        xfer_en = (phase == PH_S2) && !hold;
    end

    assign phase_dbg = phase;

    logic [WIDTH-1:0] d_link [DEPTH];
    logic [WIDTH-1:0] q_link [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign d_link[k] = in;
        end else begin : g_link
            assign d_link[k] = q_link[k-1];
        end

        tia_d1r_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk     (clk),
            .r       (r),
            .cap_en  (cap_en),
            .xfer_en (xfer_en),
            .d       (d_link[k]),
            .q       (q_link[k])
        );

        assign taps[k*WIDTH +: WIDTH] = q_link[k];
    end

    assign out = q_link[DEPTH-1];

endmodule
